// File: rtl/alu_ctrl_pkg.sv
// Shared encodings, operation selects and FSM states
// for the registered ALU control decoder.
package alu_ctrl_pkg;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_SLT = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;
   localparam logic [3:0] OP_SUB = 4'b1100;

   typedef enum logic {IDLE, MC_WAIT} state_t;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Decode-request and op-delivery handshake bundle
// between decode stage, ALU control and execute stage.
interface alu_control_seq_if #(
   parameter int OPW    = 4,
   parameter int FUNCTW = 2,
   parameter int SELW   = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        ALUOp;
   logic [OPW-1:0]    OPCode;
   logic [FUNCTW-1:0] FUNCT;
   logic              out_valid;
   logic              out_ready;
   logic [SELW-1:0]   Operacioni;
   logic              Illegal;
   logic              MCStart;
   logic              Busy;

   modport master (
      output in_valid, ALUOp, OPCode, FUNCT, out_ready,
      input  in_ready, out_valid, Operacioni, Illegal,
      input  MCStart, Busy
   );

   modport slave (
      input  in_valid, ALUOp, OPCode, FUNCT, out_ready,
      output in_ready, out_valid, Operacioni, Illegal,
      output MCStart, Busy
   );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/OPCode/FUNCT to ALU select decode,
// flagging undecodable and multi-cycle codes.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OPW    = 4,
   parameter int FUNCTW = 2
) (
   input  logic [1:0]        alu_op,
   input  logic [OPW-1:0]    opcode,
   input  logic [FUNCTW-1:0] funct,
   output logic [3:0]        op,
   output logic              illegal,
   output logic              multicycle
);

   logic oc0, oc1, oc2, oc3, oc9, oc10, oc11;
   logic f0, f1, f2;

   assign oc0  = opcode == OPW'(0);
   assign oc1  = opcode == OPW'(1);
   assign oc2  = opcode == OPW'(2);
   assign oc3  = opcode == OPW'(3);
   assign oc9  = opcode == OPW'(9);
   assign oc10 = opcode == OPW'(10);
   assign oc11 = opcode == OPW'(11);
   assign f0   = funct == FUNCTW'(0);
   assign f1   = funct == FUNCTW'(1);
   assign f2   = funct == FUNCTW'(2);

   always_comb begin
      op      = OP_AND;
      illegal = 1'b0;
      unique case (alu_op)
         ALUOP_MEM: op = OP_ADD;
         ALUOP_BR:  op = OP_SUB;
         ALUOP_R: begin
            illegal = 1'b1;
            unique case (1'b1)
               oc0 && f0: {op, illegal} = {OP_AND, 1'b0};
               oc0 && f1: {op, illegal} = {OP_OR,  1'b0};
               oc0 && f2: {op, illegal} = {OP_XOR, 1'b0};
               oc1 && f0: {op, illegal} = {OP_ADD, 1'b0};
               oc1 && f1: {op, illegal} = {OP_SUB, 1'b0};
               oc2 && f0: {op, illegal} = {OP_SLL, 1'b0};
               oc2 && f1: {op, illegal} = {OP_SRA, 1'b0};
               oc3 && f0: {op, illegal} = {OP_MUL, 1'b0};
               oc3 && f1: {op, illegal} = {OP_DIV, 1'b0};
               default: ;
            endcase
         end
         ALUOP_I: begin
            illegal = 1'b1;
            unique case (1'b1)
               oc9:  {op, illegal} = {OP_ADD, 1'b0};
               oc10: {op, illegal} = {OP_SUB, 1'b0};
               oc11: {op, illegal} = {OP_SLT, 1'b0};
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign multicycle = is_multicycle(op);

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control: one-entry valid/ready op register
// plus a wait FSM that stalls decode during MUL/DIV.
module alu_control_seq
   import alu_ctrl_pkg::*;
#(
   parameter int OPW       = 4,
   parameter int FUNCTW    = 2,
   parameter int SELW      = 4,
   parameter int MC_CYCLES = 8
) (
   input logic         Clock,
   input logic         Reset,
   alu_control_seq_if.slave bus
);

   state_t          state, state_n;
   logic [7:0]      cnt, cnt_n;
   logic            vld_q, ill_q;
   logic [SELW-1:0] op_q;
   logic [3:0]      dec_op;
   logic            dec_ill, dec_mc;
   logic            held_mc, accept, consume, mc_go;

   alu_op_decode #(
      .OPW    (OPW),
      .FUNCTW (FUNCTW)
   ) u_dec (
      .alu_op     (bus.ALUOp),
      .opcode     (bus.OPCode),
      .funct      (bus.FUNCT),
      .op         (dec_op),
      .illegal    (dec_ill),
      .multicycle (dec_mc)
   );

   assign held_mc = vld_q && is_multicycle(op_q[3:0]);
   assign consume = vld_q && bus.out_ready;
   assign mc_go   = !Reset && (state == IDLE) && consume && held_mc;
   assign accept  = bus.in_valid && bus.in_ready;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (mc_go) begin
               state_n = MC_WAIT;
               cnt_n   = 8'(MC_CYCLES - 1);
            end
         end
         MC_WAIT: begin
            cnt_n = cnt - 8'd1;
            if (cnt == 8'd1) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // a held MUL/DIV must leave alone, so no pass-through of out_ready
   always_comb begin
      bus.in_ready = !Reset && (state == IDLE) &&
                     (!vld_q || (bus.out_ready && !held_mc));
      bus.MCStart  = mc_go;
      bus.Busy     = (state == MC_WAIT);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         vld_q <= 1'b0;
         op_q  <= '0;
         ill_q <= 1'b0;
      end else if (accept) begin
         vld_q <= 1'b1;
         op_q  <= SELW'(dec_op);
         ill_q <= dec_ill;
      end else if (consume) begin
         vld_q <= 1'b0;
      end
   end

   assign bus.out_valid  = vld_q;
   assign bus.Operacioni = op_q;
   assign bus.Illegal    = ill_q;

   logic unused;
   assign unused = dec_mc;

endmodule
